bcd_counter_scan: RTL and testbench

- Multi-digit BCD up/down counter with a time-multiplexed digit scanner.
- Sits directly upstream of the team's bcd_7segment decoder.
- Presents one 4-bit BCD digit per scan slot on bcd, plus a one-hot digit-select for the display.
- Also exports the full parallel count and a wrap pulse for use elsewhere.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit.sv | 46 ++++
 rtl/bcd_counter_scan.sv | 88 ++++++++
 tb/tb_bcd_counter_scan.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and the one-hot helper used by the
// counter/scanner block and its decade cells.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX    = 4'd9;
    localparam bcd_t BCD_MIN    = 4'd0;
    localparam int   MAX_DIGITS = 8;

    // Bit idx set when it falls inside width; all zero otherwise.
    function automatic logic [MAX_DIGITS-1:0] onehot(input int idx, input int width);
        logic [MAX_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i == idx && i < width) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell: holds a BCD digit, steps up or down when step_in is high
// and raises a combinational carry/borrow when it rolls over.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic step_in,
    input  logic up,
    output bcd_t digit,
    output logic step_out
);

    bcd_t digit_q;
    bcd_t digit_d;
    logic at_edge;

    // Illegal nibbles behave like 9 going up and like 0 going down.
    always_comb begin
        at_edge = up ? (digit_q >= BCD_MAX)
                     : ((digit_q == BCD_MIN) || (digit_q > BCD_MAX));
        step_out = step_in & at_edge;
        digit_d  = digit_q;
        if (clr) begin
            digit_d = BCD_MIN;
        end else if (step_in) begin
            if (up) begin
                digit_d = at_edge ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = at_edge ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/bcd_counter_scan.sv
// Multi-digit BCD up/down counter with a prescaled digit scanner that feeds
// one nibble plus a one-hot select to a seven-segment decoder.
module bcd_counter_scan
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap,
    output bcd_t                  bcd,
    output logic [DIGITS-1:0]     an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIGITS:0] step;
    assign step[0] = en;

    // Carry/borrow ripples through the chain so a full step lands in one edge.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk      (clk),
                .rst      (rst),
                .clr      (clr),
                .step_in  (step[gi]),
                .up       (up),
                .digit    (value[4*gi +: 4]),
                .step_out (step[gi+1])
            );
        end
    endgenerate

    logic                  wrap_q, wrap_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    bcd_t                  bcd_q, bcd_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [MAX_DIGITS-1:0] sel_oh;
    logic                  presc_tc;

    always_comb begin
        wrap_d   = ~clr & step[DIGITS];
        presc_tc = (presc_q == PW'(SCAN_DIV - 1));
        presc_d  = presc_tc ? '0 : presc_q + PW'(1);
        idx_d    = idx_q;
        if (presc_tc) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        // bcd and an both follow idx_q so they always describe the same digit.
        bcd_d = BCD_MIN;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(idx_q) == i) begin
                bcd_d = value[4*i +: 4];
            end
        end
        sel_oh = onehot(int'(idx_q), DIGITS);
        an_d   = sel_oh[DIGITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q  <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            bcd_q   <= BCD_MIN;
            an_q    <= DIGITS'(1);
        end else begin
            wrap_q  <= wrap_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            bcd_q   <= bcd_d;
            an_q    <= an_d;
        end
    end

    assign wrap = wrap_q;
    assign bcd  = bcd_q;
    assign an   = an_q;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Scoreboard bench: directed steps push hand-computed expectations, a monitor
// pops one per clock and compares both a SCAN_DIV=4 and a SCAN_DIV=1 instance.
module tb_bcd_counter_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        en  = 1'b0;
    logic        up  = 1'b1;
    logic [15:0] value0, value1;
    logic        wrap0, wrap1;
    logic [3:0]  bcd0, bcd1;
    logic [3:0]  an0, an1;

    always #5 clk = ~clk;

    bcd_counter_scan #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up),
        .value(value0), .wrap(wrap0), .bcd(bcd0), .an(an0)
    );

    bcd_counter_scan #(.DIGITS(4), .SCAN_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up),
        .value(value1), .wrap(wrap1), .bcd(bcd1), .an(an1)
    );

    typedef struct packed {
        logic        chk_val;
        logic [15:0] val;
        logic        wrap;
        logic        chk_an;
        logic        chk_bcd;
        logic [3:0]  an0;
        logic [3:0]  bcd0;
        logic [3:0]  an1;
        logic [3:0]  bcd1;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    k       = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] want);
        n_total++;
        if (act === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // One clock of stimulus; the expectation is for the state after this edge.
    task automatic cyc(input logic r, input logic c, input logic e, input logic u,
                       input logic cv, input logic [15:0] v, input logic w,
                       input logic ca, input logic cb, input logic [15:0] fixed,
                       input string nm);
        exp_t it;
        int   i4, i1;
        @(negedge clk);
        rst = r; clr = c; en = e; up = u;
        if (r) k = 0;
        else   k++;
        it.chk_val = cv; it.val = v; it.wrap = w;
        it.chk_an = ca; it.chk_bcd = cb;
        if (r) begin
            it.an0 = 4'b0001; it.bcd0 = 4'd0;
            it.an1 = 4'b0001; it.bcd1 = 4'd0;
        end else begin
            i4 = ((k - 1) / 4) % 4;
            i1 = (k - 1) % 4;
            it.an0  = 4'b0001 << i4;
            it.bcd0 = 4'(fixed >> (4 * i4));
            it.an1  = 4'b0001 << i1;
            it.bcd1 = 4'(fixed >> (4 * i1));
        end
        exp_q.push_back(it);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  it;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                nm = name_q.pop_front();
                if (it.chk_val) begin
                    check({nm, "_value"},  value0, it.val);
                    check({nm, "_value1"}, value1, it.val);
                    check({nm, "_wrap"},   16'(wrap0), 16'(it.wrap));
                    check({nm, "_wrap1"},  16'(wrap1), 16'(it.wrap));
                    $display("txn %-16s value=%h wrap=%b an=%b bcd=%h", nm, value0, wrap0, an0, bcd0);
                end
                if (it.chk_an) begin
                    check({nm, "_an"},  16'(an0), 16'(it.an0));
                    check({nm, "_an1"}, 16'(an1), 16'(it.an1));
                end
                if (it.chk_bcd) begin
                    check({nm, "_bcd"},  16'(bcd0), 16'(it.bcd0));
                    check({nm, "_bcd1"}, 16'(bcd1), 16'(it.bcd1));
                end
            end
        end
    end

    initial begin : stimulus
        repeat (2)   cyc(1, 1, 1, 1, 1, 16'h0000, 0, 1, 1, 16'h0000, "reset");
        repeat (5)   cyc(0, 0, 0, 1, 1, 16'h0000, 0, 1, 1, 16'h0000, "idle_scan");
        repeat (999) cyc(0, 0, 1, 1, 0, 16'h0000, 0, 1, 0, 16'h0000, "preload");
        cyc(0, 0, 1, 1, 1, 16'h1000, 0, 1, 0, 16'h0000, "up_carry");
        cyc(0, 0, 1, 0, 1, 16'h0999, 0, 1, 0, 16'h0000, "down_borrow");
        repeat (998) cyc(0, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, "preload");
        cyc(0, 0, 1, 0, 1, 16'h0000, 0, 1, 0, 16'h0000, "down_to_zero");
        cyc(0, 0, 1, 0, 1, 16'h9999, 1, 1, 0, 16'h0000, "down_wrap");
        cyc(0, 0, 0, 0, 1, 16'h9999, 0, 1, 0, 16'h0000, "wrap_one_cycle");
        cyc(0, 0, 1, 1, 1, 16'h0000, 1, 1, 0, 16'h0000, "up_wrap");
        cyc(0, 0, 1, 1, 1, 16'h0001, 0, 1, 0, 16'h0000, "up_after_wrap");
        repeat (40)  cyc(0, 0, 1, 1, 0, 16'h0000, 0, 1, 0, 16'h0000, "preload");
        cyc(0, 0, 1, 1, 1, 16'h0042, 0, 1, 0, 16'h0000, "to_42");
        cyc(0, 1, 1, 1, 1, 16'h0000, 0, 1, 0, 16'h0000, "clr_over_en");
        cyc(0, 0, 1, 0, 1, 16'h9999, 1, 1, 0, 16'h0000, "down_wrap2");
        cyc(0, 1, 1, 1, 1, 16'h0000, 0, 1, 0, 16'h0000, "clr_blocks_wrap");
        repeat (4)   cyc(0, 0, 1, 1, 0, 16'h0000, 0, 1, 0, 16'h0000, "preload");
        cyc(0, 0, 1, 1, 1, 16'h0005, 0, 1, 0, 16'h0000, "to_5");
        cyc(1, 0, 1, 1, 1, 16'h0000, 0, 1, 1, 16'h0000, "rst_over_en");
        repeat (4320) cyc(0, 0, 1, 1, 0, 16'h0000, 0, 1, 0, 16'h0000, "preload");
        cyc(0, 0, 1, 1, 1, 16'h4321, 0, 1, 0, 16'h0000, "to_4321");
        repeat (20)  cyc(0, 0, 0, 1, 1, 16'h4321, 0, 1, 1, 16'h4321, "scan");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #3;
        n_total++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
